// File: rtl/uart_cfg_pkg.sv
// Purpose : shared constants for the configurable async receiver: FSM encoding,
//           parity-mode codes, legal parameter bounds and small helper functions.
// Latency : n/a (package). Backpressure: n/a.
package uart_cfg_pkg;

    // FSM state encoding
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_PARITY    = 3'd3;
    localparam logic [2:0] ST_STOP      = 3'd4;
    localparam logic [2:0] ST_DONE      = 3'd5;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd6;

    // Parity modes
    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Legal parameter bounds
    localparam int OS_MIN        = 8;
    localparam int OS_MAX        = 32;
    localparam int DATA_BITS_MIN = 5;
    localparam int DATA_BITS_MAX = 9;
    localparam int STOP_BITS_MIN = 1;
    localparam int STOP_BITS_MAX = 2;

    function automatic logic is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

    // 2-of-3 majority
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/rx_baud_tick.sv
// Purpose : oversample enable generator; fractional phase accumulator adds
//           BAUD*OVERSAMPLE each clk and wraps at CLK_FREQ, so the mean tick
//           rate is exact and jitter is at most one clk.
// Latency : tick is registered (one clk after the wrap). Backpressure: none.
// Ports   : clk, rst (async active-low), tick (1-clk pulse at BAUD*OVERSAMPLE).
module rx_baud_tick #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int ACC_W = 32;
    localparam int SUM_W = ACC_W + 1;
    localparam int INC   = BAUD * OVERSAMPLE;

    // At most one tick per clk can be produced.
    if (INC > CLK_FREQ || INC <= 0) begin : g_bad_rate
        $error("rx_baud_tick: BAUD*OVERSAMPLE must be positive and not exceed CLK_FREQ");
    end

    logic [ACC_W-1:0] acc;
    logic [SUM_W-1:0] sum;

    assign sum = {1'b0, acc} + SUM_W'(INC);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc  <= '0;
            tick <= 1'b0;
        end else if (sum >= SUM_W'(CLK_FREQ)) begin
            acc  <= ACC_W'(sum - SUM_W'(CLK_FREQ));
            tick <= 1'b1;
        end else begin
            acc  <= sum[ACC_W-1:0];
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/async_receiver_cfg.sv
// Purpose : configurable UART receiver (5..9 data bits, none/odd/even parity,
//           1..2 stop bits) with majority-voted mid-bit sampling and break handling.
// Latency : word presented 1 clk after the tick completing the last stop-bit vote.
// Backpressure: one-word holding register; a frame finishing while the held word
//           is unaccepted is dropped and flagged by sticky overrun.
// Ports   : clk, rst (async active-low), rxd_in (raw line), rx_data/rx_valid/
//           rx_ready (valid-ready output), parity_err, frame_err, overrun, busy.
module async_receiver_cfg
    import uart_cfg_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    // ---------------------------------------------------------------------
    // Elaboration-time parameter legality
    // ---------------------------------------------------------------------
    if (!is_pow2(OVERSAMPLE) || OVERSAMPLE < OS_MIN || OVERSAMPLE > OS_MAX) begin : g_bad_os
        $error("async_receiver_cfg: OVERSAMPLE must be a power of 2 in 8..32");
    end
    if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_bad_data
        $error("async_receiver_cfg: DATA_BITS must be in 5..9");
    end
    if (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) begin : g_bad_par
        $error("async_receiver_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_stop
        $error("async_receiver_cfg: STOP_BITS must be 1 or 2");
    end

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] SMP0 = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] SMP1 = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] SMP2 = CW'(OVERSAMPLE / 2 + 1);

    // ---------------------------------------------------------------------
    // Oversample tick
    // ---------------------------------------------------------------------
    logic tick;

    rx_baud_tick #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // ---------------------------------------------------------------------
    // Line synchronizer and edge detect
    // ---------------------------------------------------------------------
    logic       rxd_meta;
    logic       rxd_sync;
    logic       rxd_prev;
    logic [1:0] sync_fill;   // marks when rxd_sync holds a real post-reset sample
    logic       armed;       // a genuine high has been seen since reset

    // The synchronizer resets high, so a line already low at reset release would
    // otherwise look like a falling edge; armed requires a real high first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxd_meta  <= 1'b1;
            rxd_sync  <= 1'b1;
            rxd_prev  <= 1'b1;
            sync_fill <= 2'b00;
            armed     <= 1'b0;
        end else begin
            rxd_meta  <= rxd_in;
            rxd_sync  <= rxd_meta;
            rxd_prev  <= rxd_sync;
            sync_fill <= {sync_fill[0], 1'b1};
            armed     <= armed | (sync_fill[1] & rxd_sync);
        end
    end

    logic fall;
    assign fall = armed & rxd_prev & ~rxd_sync;

    // ---------------------------------------------------------------------
    // Receive FSM
    // ---------------------------------------------------------------------
    logic [2:0]           state;
    logic [CW-1:0]        tick_cnt;   // ticks since the start edge, wraps per bit
    logic [1:0]           samp;       // first two of the three mid-bit samples
    logic [DATA_BITS-1:0] shreg;
    logic [3:0]           bit_cnt;
    logic                 stop_cnt;
    logic                 pe_pend;
    logic                 fe_pend;

    logic vote_tick;
    logic voted;
    logic par_exp;
    logic counting;
    logic frame_done;

    assign counting  = (state == ST_START) || (state == ST_DATA) ||
                       (state == ST_PARITY) || (state == ST_STOP);
    assign vote_tick = tick && (tick_cnt == SMP2);
    assign voted     = maj3(samp[0], samp[1], rxd_sync);
    assign par_exp   = (PARITY == PAR_ODD) ? ~(^shreg) : ^shreg;
    // The word is committed on the same edge that enters DONE.
    assign frame_done = (state == ST_STOP) && vote_tick &&
                        (stop_cnt == 1'(STOP_BITS - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            tick_cnt <= '0;
            samp     <= 2'b11;
            shreg    <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            pe_pend  <= 1'b0;
            fe_pend  <= 1'b0;
        end else begin
            if (counting && tick) begin
                tick_cnt <= tick_cnt + 1'b1;
                if (tick_cnt == SMP0) samp[0] <= rxd_sync;
                if (tick_cnt == SMP1) samp[1] <= rxd_sync;
            end

            case (state)
                ST_IDLE: begin
                    if (fall) begin
                        state    <= ST_START;
                        tick_cnt <= '0;
                        bit_cnt  <= '0;
                        stop_cnt <= 1'b0;
                        pe_pend  <= 1'b0;
                        fe_pend  <= 1'b0;
                    end
                end
                ST_START: begin
                    if (vote_tick) state <= voted ? ST_IDLE : ST_DATA;
                end
                ST_DATA: begin
                    if (vote_tick) begin
                        shreg   <= {voted, shreg[DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'(DATA_BITS - 1))
                            state <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end
                end
                ST_PARITY: begin
                    if (vote_tick) begin
                        if (voted != par_exp) pe_pend <= 1'b1;
                        state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (vote_tick) begin
                        if (!voted) fe_pend <= 1'b1;
                        if (frame_done) state <= ST_DONE;
                        else            stop_cnt <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= fe_pend ? ST_WAIT_IDLE : ST_IDLE;
                end
                ST_WAIT_IDLE: begin
                    // A break holds the line low; wait for it to release.
                    if (rxd_sync) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state != ST_IDLE);

    // ---------------------------------------------------------------------
    // Output holding register
    // ---------------------------------------------------------------------
    logic new_fe;
    assign new_fe = fe_pend | ~voted;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else if (rx_valid && rx_ready) begin
            overrun <= 1'b0;
            if (frame_done) begin
                // Back-to-back: the slot frees on this edge, so take the new word.
                rx_data    <= shreg;
                parity_err <= pe_pend;
                frame_err  <= new_fe;
            end else begin
                rx_valid <= 1'b0;
            end
        end else if (frame_done) begin
            if (rx_valid) begin
                overrun <= 1'b1;
            end else begin
                rx_data    <= shreg;
                rx_valid   <= 1'b1;
                parity_err <= pe_pend;
                frame_err  <= new_fe;
            end
        end
    end

endmodule

// File: tb/tb_async_receiver_cfg.sv
`timescale 1ns/1ps
module tb_async_receiver_cfg;

    localparam realtime BIT_NS = 1.0e9 / 115200.0;

    logic clk = 1'b0;
    always #10 clk = ~clk;   // 50 MHz

    logic       rst;
    logic       rxd_a, rdy_a, vld_a, pe_a, fe_a, ov_a, busy_a;
    logic [7:0] data_a;
    logic       rxd_b, rdy_b, vld_b, pe_b, fe_b, ov_b, busy_b;
    logic [6:0] data_b;

    async_receiver_cfg u_dut_a (
        .clk(clk), .rst(rst), .rxd_in(rxd_a),
        .rx_data(data_a), .rx_valid(vld_a), .rx_ready(rdy_a),
        .parity_err(pe_a), .frame_err(fe_a), .overrun(ov_a), .busy(busy_a)
    );

    async_receiver_cfg #(.DATA_BITS(7), .PARITY(2)) u_dut_b (
        .clk(clk), .rst(rst), .rxd_in(rxd_b),
        .rx_data(data_b), .rx_valid(vld_b), .rx_ready(rdy_b),
        .parity_err(pe_b), .frame_err(fe_b), .overrun(ov_b), .busy(busy_b)
    );

    typedef struct packed {
        logic       ov;
        logic       fe;
        logic       pe;
        logic [8:0] data;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb;
    int   checks = 0;
    int   errors = 0;
    int   vcnt_a = 0;

    function automatic exp_t mk(input logic ov, input logic fe, input logic pe,
                                input logic [8:0] d);
        exp_t e;
        e.ov = ov; e.fe = fe; e.pe = pe; e.data = d;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Monitors: pop and compare on every handshake.
    always @(negedge clk) begin
        if (rst && vld_a) vcnt_a++;
        if (rst && vld_a && rdy_a) begin
            if (q_a.size() == 0) begin
                checks++; errors++;
                $display("FAIL word_a unexpected actual=0x%0h required=none", data_a);
            end else begin
                ea = q_a.pop_front();
                check("word_a {ov,fe,pe,data}",
                      {20'd0, ov_a, fe_a, pe_a, 1'b0, data_a}, 32'(ea));
            end
        end
        if (rst && vld_b && rdy_b) begin
            if (q_b.size() == 0) begin
                checks++; errors++;
                $display("FAIL word_b unexpected actual=0x%0h required=none", data_b);
            end else begin
                eb = q_b.pop_front();
                check("word_b {ov,fe,pe,data}",
                      {20'd0, ov_b, fe_b, pe_b, 2'b0, data_b}, 32'(eb));
            end
        end
    end

    task automatic drive(input int line, input logic v, input real nbits);
        if (line == 0) rxd_a = v;
        else           rxd_b = v;
        #(BIT_NS * nbits);
    endtask

    task automatic send_frame(input int line, input logic [8:0] d, input int nbits,
                              input int par, input bit flip_par, input logic stop_v);
        logic p;
        p = 1'b0;
        drive(line, 1'b0, 1.0);
        for (int i = 0; i < nbits; i++) begin
            drive(line, d[i], 1.0);
            p = p ^ d[i];
        end
        if (par != 0) begin
            if (par == 1) p = ~p;
            if (flip_par) p = ~p;
            drive(line, p, 1.0);
        end
        drive(line, stop_v, 1.0);
    endtask

    task automatic wait_drain(input int line, input string name);
        int n;
        n = 0;
        while (((line == 0) ? q_a.size() : q_b.size()) != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        check(name, (line == 0) ? q_a.size() : q_b.size(), 0);
    endtask

    initial begin
        #(BIT_NS * 180.0);
        $display("FAIL watchdog expired actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; rxd_a = 1'b1; rxd_b = 1'b1; rdy_a = 1'b1; rdy_b = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("reset rx_valid", vld_a, 0);
        check("reset rx_data", data_a, 0);
        check("reset parity_err", pe_a, 0);
        check("reset frame_err", fe_a, 0);
        check("reset overrun", ov_a, 0);
        check("reset busy", busy_a, 0);
        check("reset b rx_valid", vld_b, 0);
        rst = 1'b1;
        repeat (20) @(posedge clk);

        // 8N1 0xA5, always ready
        vcnt_a = 0;
        q_a.push_back(mk(1'b0, 1'b0, 1'b0, 9'h0A5));
        send_frame(0, 9'h0A5, 8, 0, 1'b0, 1'b1);
        drive(0, 1'b1, 1.0);
        wait_drain(0, "a5 delivered");
        check("a5 valid cycles", vcnt_a, 1);

        // 0.3-bit glitch: false start
        vcnt_a = 0;
        rxd_a = 1'b0;
        #(BIT_NS * 0.3);
        @(negedge clk);
        check("glitch busy during", busy_a, 1);
        rxd_a = 1'b1;
        #(BIT_NS * 0.6);
        @(negedge clk);
        check("glitch busy after", busy_a, 0);
        drive(0, 1'b1, 1.0);
        check("glitch no valid", vcnt_a, 0);

        // Overrun: 0x11 held, 0x22 dropped
        @(posedge clk); #1 rdy_a = 1'b0;
        q_a.push_back(mk(1'b1, 1'b0, 1'b0, 9'h011));
        send_frame(0, 9'h011, 8, 0, 1'b0, 1'b1);
        send_frame(0, 9'h022, 8, 0, 1'b0, 1'b1);
        drive(0, 1'b1, 1.0);
        @(negedge clk);
        check("ovr held valid", vld_a, 1);
        check("ovr held data", data_a, 8'h11);
        check("ovr flag", ov_a, 1);
        @(posedge clk); #1 rdy_a = 1'b1;
        @(posedge clk); #1 rdy_a = 1'b0;
        @(negedge clk);
        check("ovr valid after hs", vld_a, 0);
        check("ovr overrun after hs", ov_a, 0);
        wait_drain(0, "ovr word popped");

        // Break: line low for 2 frame times
        @(posedge clk); #1 rdy_a = 1'b1;
        q_a.push_back(mk(1'b0, 1'b1, 1'b0, 9'h000));
        rxd_a = 1'b0;
        #(BIT_NS * 20.0);
        @(negedge clk);
        check("break busy while low", busy_a, 1);
        rxd_a = 1'b1;
        #(BIT_NS * 1.0);
        @(negedge clk);
        check("break busy after high", busy_a, 0);
        wait_drain(0, "break word");

        // Reset mid-frame with a word held
        @(posedge clk); #1 rdy_a = 1'b0;
        send_frame(0, 9'h05A, 8, 0, 1'b0, 1'b1);
        drive(0, 1'b1, 1.0);
        @(negedge clk);
        check("pre-reset valid", vld_a, 1);
        check("pre-reset data", data_a, 8'h5A);
        drive(0, 1'b0, 1.0);                 // start
        for (int i = 0; i < 4; i++) drive(0, 1'b0, 1.0);
        #(BIT_NS * 0.5);                     // middle of data bit 4
        @(negedge clk);
        check("mid-frame busy", busy_a, 1);
        rst = 1'b0;
        #1;
        check("rst valid", vld_a, 0);
        check("rst data", data_a, 0);
        check("rst overrun", ov_a, 0);
        check("rst busy", busy_a, 0);
        repeat (10) @(posedge clk);
        #1 rst = 1'b1; rdy_a = 1'b1;
        #(BIT_NS * 2.0);                     // line still low: no fresh edge
        @(negedge clk);
        check("post-rst low line busy", busy_a, 0);
        drive(0, 1'b1, 2.0);
        q_a.push_back(mk(1'b0, 1'b0, 1'b0, 9'h03C));
        send_frame(0, 9'h03C, 8, 0, 1'b0, 1'b1);
        drive(0, 1'b1, 1.0);
        wait_drain(0, "3c delivered");

        // 7E1: bad parity then good parity
        q_b.push_back(mk(1'b0, 1'b0, 1'b1, 9'h041));
        send_frame(1, 9'h041, 7, 2, 1'b1, 1'b1);
        drive(1, 1'b1, 1.0);
        q_b.push_back(mk(1'b0, 1'b0, 1'b0, 9'h02B));
        send_frame(1, 9'h02B, 7, 2, 1'b0, 1'b1);
        drive(1, 1'b1, 1.0);
        wait_drain(1, "b words delivered");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
